// File: rtl/tqvp_affinex_stream.sv
// TinyQV peripheral: streaming 2-D fixed-point affine transform with input/output point FIFOs.
// One shared multiplier issues one product per cycle; each point takes 6 cycles.
module tqvp_affinex_stream #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW = 2*WIDTH + 2;
  localparam int EW = 2*WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam logic signed [AW-1:0] MAX_R = AW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [AW-1:0] MIN_R = ~MAX_R;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [1:0]  wn);
    case (wn)
      2'b00:   return {old[31:8], din[7:0]};
      2'b01:   return {old[31:16], din[15:0]};
      default: return din;
    endcase
  endfunction

  function automatic logic out_of_range(input logic signed [AW-1:0] r);
    return (r > MAX_R) || (r < MIN_R);
  endfunction

  function automatic logic signed [WIDTH-1:0] fit(input logic signed [AW-1:0] r,
                                                  input logic sat);
    logic signed [AW-1:0] c;
    c = r;
    if (sat && (r > MAX_R))      c = MAX_R;
    else if (sat && (r < MIN_R)) c = MIN_R;
    return c[WIDTH-1:0];
  endfunction

  logic                    en_q, sat_q, irq_en_q;
  logic                    ovf_q, unf_q, sat_hit_q;
  logic signed [WIDTH-1:0] coef_a, coef_b, coef_d, coef_e, tx, ty;
  state_t                  state;
  logic [1:0]              stage;

  logic [EW-1:0] in_mem  [DEPTH];
  logic [EW-1:0] out_mem [DEPTH];
  logic [PW-1:0] in_wp, in_rp, out_wp, out_rp;
  logic [PW:0]   in_cnt, out_cnt;

  logic wr_any, rd_any, clear_pulse, status_wr;
  logic push_req, push_ok, push_drop, pop_req, cpu_pop, pop_unf;
  logic in_full, in_empty, out_full, out_empty, busy;
  logic eng_pop, eng_push;

  assign uo_out     = 8'h00;
  assign data_ready = 1'b1;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  assign wr_any      = (data_write_n != 2'b11);
  assign rd_any      = (data_read_n != 2'b11);
  assign clear_pulse = wr_any && (address == 6'h00) && data_in[3];
  assign status_wr   = wr_any && (address == 6'h04);
  assign push_req    = (data_write_n == 2'b10) && (address == 6'h20);
  assign push_ok     = push_req && !in_full;
  assign push_drop   = push_req && in_full;
  assign pop_req     = rd_any && (address == 6'h24);
  assign cpu_pop     = pop_req && !out_empty;
  assign pop_unf     = pop_req && out_empty;

  assign in_full   = (in_cnt == FULL_CNT);
  assign in_empty  = (in_cnt == '0);
  assign out_full  = (out_cnt == FULL_CNT);
  assign out_empty = (out_cnt == '0);
  assign busy      = (state != S_IDLE);

  assign eng_pop  = (state == S_IDLE) && en_q && !in_empty && !out_full && !clear_pulse;
  assign eng_push = (state == S_WB) && !clear_pulse;

  assign user_interrupt = irq_en_q && !out_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      sat_q    <= 1'b0;
      irq_en_q <= 1'b0;
      coef_a   <= '0;
      coef_b   <= '0;
      coef_d   <= '0;
      coef_e   <= '0;
      tx       <= '0;
      ty       <= '0;
    end else if (wr_any) begin
      case (address)
        6'h00: begin
          en_q     <= data_in[0];
          sat_q    <= data_in[1];
          irq_en_q <= data_in[2];
        end
        6'h08: coef_a <= WIDTH'(merge_bytes(32'(coef_a), data_in, data_write_n));
        6'h0C: coef_b <= WIDTH'(merge_bytes(32'(coef_b), data_in, data_write_n));
        6'h10: coef_d <= WIDTH'(merge_bytes(32'(coef_d), data_in, data_write_n));
        6'h14: coef_e <= WIDTH'(merge_bytes(32'(coef_e), data_in, data_write_n));
        6'h18: tx     <= WIDTH'(merge_bytes(32'(tx), data_in, data_write_n));
        6'h1C: ty     <= WIDTH'(merge_bytes(32'(ty), data_in, data_write_n));
        default: ;
      endcase
    end
  end

  // ---- Stage p0: point and coefficient snapshot; shared multiplier operand select
  logic signed [WIDTH-1:0] x_p0, y_p0, a_p0, b_p0, d_p0, e_p0, tx_p0, ty_p0;
  logic signed [WIDTH-1:0] mul_coef, mul_opd;
  logic signed [EW-1:0]    prod;
  logic [EW-1:0]           in_head;

  assign in_head = in_mem[in_rp];

  always_comb begin
    case (stage)
      2'd1:    mul_coef = b_p0;
      2'd2:    mul_coef = d_p0;
      2'd3:    mul_coef = e_p0;
      default: mul_coef = a_p0;
    endcase
    mul_opd = stage[0] ? y_p0 : x_p0;
  end

  assign prod = EW'(mul_coef) * EW'(mul_opd);

  // ---- Stage p1: accumulation, x terms in stages 0-1 and y terms in stages 2-3
  logic signed [AW-1:0] acc_x_p1, acc_y_p1;

  always_ff @(posedge clk) begin
    if (eng_pop) begin
      x_p0     <= in_head[WIDTH-1:0];
      y_p0     <= in_head[EW-1:WIDTH];
      a_p0     <= coef_a;
      b_p0     <= coef_b;
      d_p0     <= coef_d;
      e_p0     <= coef_e;
      tx_p0    <= tx;
      ty_p0    <= ty;
      acc_x_p1 <= '0;
      acc_y_p1 <= '0;
    end else if (state == S_MAC) begin
      if (!stage[1]) acc_x_p1 <= acc_x_p1 + AW'(prod);
      else           acc_y_p1 <= acc_y_p1 + AW'(prod);
    end
  end

  // ---- Stage p2: scale, translate, then clamp or wrap on the way into the output FIFO
  logic signed [AW-1:0] res_x_p2, res_y_p2;
  logic [EW-1:0]        wb_data_p2;
  logic                 clamp_p2;

  assign res_x_p2   = (acc_x_p1 >>> FRAC) + AW'(tx_p0);
  assign res_y_p2   = (acc_y_p1 >>> FRAC) + AW'(ty_p0);
  assign wb_data_p2 = {fit(res_y_p2, sat_q), fit(res_x_p2, sat_q)};
  assign clamp_p2   = sat_q && (out_of_range(res_x_p2) || out_of_range(res_y_p2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      stage <= 2'd0;
    end else if (clear_pulse) begin
      state <= S_IDLE;
      stage <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (eng_pop) begin
          state <= S_MAC;
          stage <= 2'd0;
        end
        S_MAC: begin
          stage <= stage + 2'd1;
          if (stage == 2'd3) state <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      sat_hit_q <= 1'b0;
    end else if (clear_pulse) begin
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      sat_hit_q <= 1'b0;
    end else begin
      if (push_drop)                  ovf_q <= 1'b1;
      else if (status_wr && data_in[5]) ovf_q <= 1'b0;
      if (pop_unf)                    unf_q <= 1'b1;
      else if (status_wr && data_in[6]) unf_q <= 1'b0;
      if (eng_push && clamp_p2)       sat_hit_q <= 1'b1;
      else if (status_wr && data_in[7]) sat_hit_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else if (clear_pulse) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (push_ok) in_wp <= in_wp + 1'b1;
      if (eng_pop) in_rp <= in_rp + 1'b1;
      in_cnt <= in_cnt + (PW+1)'(push_ok) - (PW+1)'(eng_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) in_mem[in_wp] <= {data_in[16+WIDTH-1:16], data_in[WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else if (clear_pulse) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (eng_push) out_wp <= out_wp + 1'b1;
      if (cpu_pop)  out_rp <= out_rp + 1'b1;
      out_cnt <= out_cnt + (PW+1)'(eng_push) - (PW+1)'(cpu_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (eng_push) out_mem[out_wp] <= wb_data_p2;
  end

  logic [EW-1:0]           out_head;
  logic signed [WIDTH-1:0] pop_x, pop_y;
  logic signed [15:0]      pop_x16, pop_y16;
  logic [7:0]              status;

  assign out_head = out_mem[out_rp];
  assign pop_x    = out_head[WIDTH-1:0];
  assign pop_y    = out_head[EW-1:WIDTH];
  assign pop_x16  = 16'(pop_x);
  assign pop_y16  = 16'(pop_y);
  assign status   = {sat_hit_q, unf_q, ovf_q, out_empty, out_full, in_empty, in_full, busy};

  always_comb begin
    data_out = 32'h0;
    case (address)
      6'h00: data_out = {29'h0, irq_en_q, sat_q, en_q};
      6'h04: data_out = {24'h0, status};
      6'h08: data_out = 32'(coef_a);
      6'h0C: data_out = 32'(coef_b);
      6'h10: data_out = 32'(coef_d);
      6'h14: data_out = 32'(coef_e);
      6'h18: data_out = 32'(tx);
      6'h1C: data_out = 32'(ty);
      6'h24: data_out = out_empty ? 32'h0 : {pop_y16, pop_x16};
      default: data_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_affinex_stream.sv
// Directed bench for tqvp_affinex_stream: vector table of single-point transforms plus
// hand sequences for latency, FIFO overflow/backpressure, CLEAR and asynchronous reset.
module tb_tqvp_affinex_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_affinex_stream #(.WIDTH(16), .FRAC(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] a, b, d, e, tx, ty, x, y;
    logic        sat;
    logic [15:0] ex, ey;
    logic        esat;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    data_read_n = 2'b10;
    #1 d = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1 d = data_out;
  endtask

  task automatic set_coefs(input logic [15:0] a, b, d, e, tx, ty);
    wr(6'h08, {16'h0, a}, 2'b10);
    wr(6'h0C, {16'h0, b}, 2'b10);
    wr(6'h10, {16'h0, d}, 2'b10);
    wr(6'h14, {16'h0, e}, 2'b10);
    wr(6'h18, {16'h0, tx}, 2'b10);
    wr(6'h1C, {16'h0, ty}, 2'b10);
  endtask

  task automatic push_when_room(input logic [31:0] pt);
    logic [31:0] s;
    int t;
    t = 0;
    peek(6'h04, s);
    while (s[1] && t < 50) begin
      @(negedge clk);
      peek(6'h04, s);
      t++;
    end
    check("push room", {31'h0, s[1]}, 32'h0);
    wr(6'h20, pt, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, s;
    vt[0] = '{16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h000A, 16'hFFFB, 16'h0064, 16'h0028, 1'b0, 16'h00E6, 16'hFFBF, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, 1'b1};
    vt[2] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'hFF00, 16'h0000, 1'b0};
    vt[3] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'hFFFD, 16'h0007, 16'hFFCE, 16'h04D2, 1'b0, 16'hFFCB, 16'h04D9, 1'b0};
    vt[4] = '{16'h0080, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'hFFFD, 16'h0003, 1'b0, 16'hFFFE, 16'h0001, 1'b0};
    vt[5] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 16'h0000, 1'b1};
    vt[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h0080, 16'h0000, 1'b0};
    vt[7] = '{16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h000B, 16'h0016, 1'b0, 16'h0016, 16'h000B, 1'b0};
    vt[8] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
    vt[9] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 1'b0, 16'h8000, 16'h7FFF, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    peek(6'h04, s);  check("reset status", s, 32'h14);
    peek(6'h24, r);  check("reset pop", r, 32'h0);
    peek(6'h00, r);  check("reset ctrl", r, 32'h0);
    peek(6'h08, r);  check("reset A", r, 32'h0);
    check("reset irq", {31'h0, user_interrupt}, 32'h0);
    check("uo_out", {24'h0, uo_out}, 32'h0);
    check("data_ready", {31'h0, data_ready}, 32'h1);

    // Narrow PUSH writes are ignored
    wr(6'h20, 32'h0001_0002, 2'b01);
    wr(6'h20, 32'h0001_0002, 2'b00);
    peek(6'h04, s);  check("narrow push ignored", s, 32'h14);

    // Single point: latency, busy, interrupt, underflow
    set_coefs(16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h000A, 16'hFFFB);
    wr(6'h00, 32'h5, 2'b10);
    peek(6'h10, r);  check("D sign-extended", r, 32'hFFFF_FF00);
    peek(6'h1C, r);  check("TY sign-extended", r, 32'hFFFF_FFFB);
    wr(6'h20, 32'h0028_0064, 2'b10);
    check("irq before result", {31'h0, user_interrupt}, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      peek(6'h04, s);
      if (k == 1) check("busy after pop edge", {31'h0, s[0]}, 32'h1);
      if (k == 5) check("WB: busy, out empty", {30'h0, s[4], s[0]}, 32'h3);
      if (k == 6) begin
        check("after WB: idle, out not empty", {30'h0, s[4], s[0]}, 32'h0);
        check("irq after WB", {31'h0, user_interrupt}, 32'h1);
      end
    end
    rd(6'h24, r);    check("T1 pop", r, 32'hFFBF_00E6);
    check("irq after last pop", {31'h0, user_interrupt}, 32'h0);
    rd(6'h24, r);    check("pop on empty", r, 32'h0);
    peek(6'h04, s);  check("unf sticky", {31'h0, s[6]}, 32'h1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      set_coefs(vt[i].a, vt[i].b, vt[i].d, vt[i].e, vt[i].tx, vt[i].ty);
      wr(6'h00, {30'h0, vt[i].sat, 1'b1}, 2'b10);
      wr(6'h04, 32'hE0, 2'b10);
      wr(6'h20, {vt[i].y, vt[i].x}, 2'b10);
      repeat (8) @(negedge clk);
      peek(6'h04, s);
      check($sformatf("vec%0d sat_hit", i), {31'h0, s[7]}, {31'h0, vt[i].esat});
      rd(6'h24, r);
      check($sformatf("vec%0d pop", i), r, {vt[i].ey, vt[i].ex});
    end

    // Input overflow with engine disabled, then drain in order
    wr(6'h00, 32'h0, 2'b10);
    wr(6'h04, 32'hE0, 2'b10);
    set_coefs(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
    for (int i = 1; i <= 5; i++) wr(6'h20, {16'(-i), 16'(3*i)}, 2'b10);
    peek(6'h04, s);  check("ovf/in_full status", s, 32'h32);
    wr(6'h04, 32'h20, 2'b10);
    peek(6'h04, s);  check("ovf cleared", s, 32'h12);
    wr(6'h00, 32'h1, 2'b10);
    repeat (30) @(negedge clk);
    peek(6'h04, s);  check("drained to out_full", s, 32'h0C);
    for (int i = 1; i <= 4; i++) begin
      rd(6'h24, r);
      check($sformatf("ovf order %0d", i), r, {16'(-i), 16'(3*i)});
    end
    peek(6'h04, s);  check("after drain", s, 32'h14);

    // Output backpressure: six points, engine stalls on out_full
    for (int j = 0; j < 6; j++) push_when_room({16'(-200 + j), 16'(100 + j)});
    repeat (40) @(negedge clk);
    peek(6'h04, s);  check("stalled on out_full", s, 32'h08);
    rd(6'h24, r);    check("bp pop 0", r, {16'(-200), 16'(100)});
    @(negedge clk);
    peek(6'h04, s);  check("engine resumes", {31'h0, s[0]}, 32'h1);
    for (int j = 1; j < 6; j++) begin
      repeat (8) @(negedge clk);
      rd(6'h24, r);
      check($sformatf("bp pop %0d", j), r, {16'(-200 + j), 16'(100 + j)});
    end

    // CLEAR during MAC stage 2
    wr(6'h20, 32'h0002_0001, 2'b10);
    wr(6'h20, 32'h0004_0003, 2'b10);
    wr(6'h00, 32'h9, 2'b10);
    peek(6'h04, s);  check("status after CLEAR", s, 32'h14);
    peek(6'h00, r);  check("ctrl after CLEAR", r, 32'h1);
    repeat (12) @(negedge clk);
    peek(6'h04, s);  check("no output after CLEAR", s, 32'h14);
    peek(6'h08, r);  check("A kept after CLEAR", r, 32'h100);

    // Asynchronous reset during MAC
    wr(6'h20, 32'h0006_0005, 2'b10);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    peek(6'h04, s);  check("status in reset", s, 32'h14);
    peek(6'h24, r);  check("pop in reset", r, 32'h0);
    peek(6'h08, r);  check("A in reset", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    peek(6'h04, s);  check("no result after reset", s, 32'h14);
    check("irq after reset", {31'h0, user_interrupt}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
